// File: rtl/synth_pkg.sv
// Shared definitions for the PS/2 key event controller: scan codes, parser
// states, note index type and small decode helpers.
package synth_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;

  // Note keys, ascending note index 0 (C) .. 11 (B)
  localparam logic [7:0] SC_N0  = 8'h1C;
  localparam logic [7:0] SC_N1  = 8'h1D;
  localparam logic [7:0] SC_N2  = 8'h1B;
  localparam logic [7:0] SC_N3  = 8'h24;
  localparam logic [7:0] SC_N4  = 8'h23;
  localparam logic [7:0] SC_N5  = 8'h2B;
  localparam logic [7:0] SC_N6  = 8'h2C;
  localparam logic [7:0] SC_N7  = 8'h34;
  localparam logic [7:0] SC_N8  = 8'h35;
  localparam logic [7:0] SC_N9  = 8'h33;
  localparam logic [7:0] SC_N10 = 8'h3C;
  localparam logic [7:0] SC_N11 = 8'h3B;

  // Control keys
  localparam logic [7:0] SC_OCT_DN = 8'h1A;
  localparam logic [7:0] SC_OCT_UP = 8'h22;
  localparam logic [7:0] SC_AMP_DN = 8'h16;
  localparam logic [7:0] SC_AMP_UP = 8'h1E;

  localparam int unsigned NumNotes = 12;

  typedef logic [3:0] note_idx_t;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBrk    = 2'd1,
    StExt    = 2'd2,
    StExtBrk = 2'd3
  } parse_state_e;

  // Index into the private control held-flag vector
  typedef enum logic [1:0] {
    CtrlOctDn = 2'd0,
    CtrlOctUp = 2'd1,
    CtrlAmpDn = 2'd2,
    CtrlAmpUp = 2'd3
  } ctrl_e;

  typedef struct packed {
    logic      valid;
    note_idx_t idx;
  } note_dec_t;

  typedef struct packed {
    logic  valid;
    ctrl_e code;
  } ctrl_dec_t;

  function automatic note_dec_t note_decode(input logic [7:0] b);
    note_dec_t d;
    d.valid = 1'b1;
    d.idx   = 4'd0;
    case (b)
      SC_N0:   d.idx = 4'd0;
      SC_N1:   d.idx = 4'd1;
      SC_N2:   d.idx = 4'd2;
      SC_N3:   d.idx = 4'd3;
      SC_N4:   d.idx = 4'd4;
      SC_N5:   d.idx = 4'd5;
      SC_N6:   d.idx = 4'd6;
      SC_N7:   d.idx = 4'd7;
      SC_N8:   d.idx = 4'd8;
      SC_N9:   d.idx = 4'd9;
      SC_N10:  d.idx = 4'd10;
      SC_N11:  d.idx = 4'd11;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic ctrl_dec_t ctrl_decode(input logic [7:0] b);
    ctrl_dec_t d;
    d.valid = 1'b1;
    d.code  = CtrlOctDn;
    case (b)
      SC_OCT_DN: d.code = CtrlOctDn;
      SC_OCT_UP: d.code = CtrlOctUp;
      SC_AMP_DN: d.code = CtrlAmpDn;
      SC_AMP_UP: d.code = CtrlAmpUp;
      default:   d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/held_prio_enc.sv
// Highest-set-bit encoder over the 12 held-note flags.
module held_prio_enc
  import synth_pkg::*;
(
  input  logic [11:0] req_i,
  output note_idx_t   idx_o,
  output logic        valid_o
);

  // Ascending scan so the highest set bit wins
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req_i[i]) begin
        idx_o   = note_idx_t'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// PS/2 set-2 scan-code parser turning key make/break events into note,
// gate, note_on/note_off pulses and octave/amplitude steps.
module key_event_ctrl
  import synth_pkg::*;
#(
  parameter int unsigned OCT_DEFAULT = 4,
  parameter int unsigned AMP_DEFAULT = 4
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        scan_valid,
  input  logic [7:0]  scan_byte,
  output logic [3:0]  note,
  output logic        gate,
  output logic        note_on,
  output logic        note_off,
  output logic [2:0]  octave,
  output logic [2:0]  amp,
  output logic [11:0] held
);

  parse_state_e state_q, state_d;
  note_idx_t    note_q, note_d;
  logic         gate_q, gate_d;
  logic         on_q, on_d;
  logic         off_q, off_d;
  logic [2:0]   oct_q, oct_d;
  logic [2:0]   amp_q, amp_d;
  logic [11:0]  held_q, held_d;
  logic [3:0]   ctrl_held_q, ctrl_held_d;

  note_dec_t  note_dec;
  ctrl_dec_t  ctrl_dec;
  logic [11:0] held_rem;
  note_idx_t  rem_idx;
  logic       rem_valid;

  assign note_dec = note_decode(scan_byte);
  assign ctrl_dec = ctrl_decode(scan_byte);

  // Held set as it would look after releasing the key in scan_byte
  assign held_rem = held_q & ~(12'b1 << note_dec.idx);

  held_prio_enc u_prio (
    .req_i   (held_rem),
    .idx_o   (rem_idx),
    .valid_o (rem_valid)
  );

  // Parser FSM plus make/break processing of the completing byte
  always_comb begin
    logic do_make;
    logic do_break;

    state_d     = state_q;
    note_d      = note_q;
    gate_d      = gate_q;
    on_d        = 1'b0;
    off_d       = 1'b0;
    oct_d       = oct_q;
    amp_d       = amp_q;
    held_d      = held_q;
    ctrl_held_d = ctrl_held_q;
    do_make     = 1'b0;
    do_break    = 1'b0;

    if (scan_valid) begin
      unique case (state_q)
        StIdle: begin
          if (scan_byte == SC_BRK)      state_d = StBrk;
          else if (scan_byte == SC_EXT) state_d = StExt;
          else                          do_make = 1'b1;
        end
        StBrk: begin
          do_break = 1'b1;
          state_d  = StIdle;
        end
        StExt: begin
          state_d = (scan_byte == SC_BRK) ? StExtBrk : StIdle;
        end
        StExtBrk: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end

    if (do_make) begin
      if (note_dec.valid && !held_q[note_dec.idx]) begin
        held_d[note_dec.idx] = 1'b1;
        note_d = note_dec.idx;
        gate_d = 1'b1;
        on_d   = 1'b1;
      end else if (ctrl_dec.valid && !ctrl_held_q[ctrl_dec.code]) begin
        ctrl_held_d[ctrl_dec.code] = 1'b1;
        unique case (ctrl_dec.code)
          CtrlOctDn: if (oct_q != 3'd0) oct_d = oct_q - 3'd1;
          CtrlOctUp: if (oct_q != 3'd7) oct_d = oct_q + 3'd1;
          CtrlAmpDn: if (amp_q != 3'd0) amp_d = amp_q - 3'd1;
          CtrlAmpUp: if (amp_q != 3'd7) amp_d = amp_q + 3'd1;
          default: ;
        endcase
      end
    end

    if (do_break) begin
      if (note_dec.valid && held_q[note_dec.idx]) begin
        held_d = held_rem;
        if (rem_valid) begin
          // Only retarget when the sounding note was the one released
          if (note_dec.idx == note_q) begin
            note_d = rem_idx;
            on_d   = 1'b1;
          end
        end else begin
          gate_d = 1'b0;
          off_d  = 1'b1;
        end
      end else if (ctrl_dec.valid) begin
        ctrl_held_d[ctrl_dec.code] = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      note_q      <= 4'd0;
      gate_q      <= 1'b0;
      on_q        <= 1'b0;
      off_q       <= 1'b0;
      oct_q       <= 3'(OCT_DEFAULT);
      amp_q       <= 3'(AMP_DEFAULT);
      held_q      <= 12'd0;
      ctrl_held_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      note_q      <= note_d;
      gate_q      <= gate_d;
      on_q        <= on_d;
      off_q       <= off_d;
      oct_q       <= oct_d;
      amp_q       <= amp_d;
      held_q      <= held_d;
      ctrl_held_q <= ctrl_held_d;
    end
  end

  assign note     = note_q;
  assign gate     = gate_q;
  assign note_on  = on_q;
  assign note_off = off_q;
  assign octave   = oct_q;
  assign amp      = amp_q;
  assign held     = held_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed table-driven bench for key_event_ctrl.
module tb_key_event_ctrl;

  logic        clk;
  logic        resetn;
  logic        scan_valid;
  logic [7:0]  scan_byte;
  logic [3:0]  note;
  logic        gate;
  logic        note_on;
  logic        note_off;
  logic [2:0]  octave;
  logic [2:0]  amp;
  logic [11:0] held;

  int n_checks = 0;
  int n_err    = 0;

  key_event_ctrl #(
    .OCT_DEFAULT (4),
    .AMP_DEFAULT (4)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .scan_valid (scan_valid),
    .scan_byte  (scan_byte),
    .note       (note),
    .gate       (gate),
    .note_on    (note_on),
    .note_off   (note_off),
    .octave     (octave),
    .amp        (amp),
    .held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    logic [3:0]  note;
    logic        gate;
    logic        on;
    logic        off;
    logic [11:0] held;
    logic [2:0]  oct;
    logic [2:0]  amp;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [7:0] b, input logic [3:0] n, input logic g,
                              input logic on, input logic off, input logic [11:0] h,
                              input logic [2:0] o, input logic [2:0] a);
    vec_t v;
    v.b = b; v.note = n; v.gate = g; v.on = on; v.off = off;
    v.held = h; v.oct = o; v.amp = a;
    vq.push_back(v);
  endfunction

  // note, gate, note_on, note_off, held, octave, amp
  function automatic logic [24:0] pack(input logic [3:0] n, input logic g, input logic on,
                                       input logic off, input logic [11:0] h,
                                       input logic [2:0] o, input logic [2:0] a);
    return {n, g, on, off, h, o, a};
  endfunction

  task automatic check(input string name, input logic [24:0] exp);
    logic [24:0] act;
    act = pack(note, gate, note_on, note_off, held, octave, amp);
    n_checks++;
    if (act !== exp || (note_on && note_off)) begin
      n_err++;
      $display("FAIL %s: got note=%0d gate=%0b on=%0b off=%0b held=%03h oct=%0d amp=%0d, want %07h (packed), got %07h",
               name, note, gate, note_on, note_off, held, octave, amp, exp, act);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_valid = 1'b1;
    scan_byte  = b;
    @(posedge clk);
    #1;
    scan_valid = 1'b0;
  endtask

  initial begin
    scan_valid = 1'b0;
    scan_byte  = 8'h00;
    resetn     = 1'b0;

    // Make/repeat/break of a single key
    add(8'h1C, 0, 1, 1, 0, 12'h001, 4, 4);
    add(8'h1C, 0, 1, 0, 0, 12'h001, 4, 4);
    add(8'h1C, 0, 1, 0, 0, 12'h001, 4, 4);
    add(8'hF0, 0, 1, 0, 0, 12'h001, 4, 4);
    add(8'h1C, 0, 0, 0, 1, 12'h000, 4, 4);
    // Two keys, release the sounding one
    add(8'h1C, 0, 1, 1, 0, 12'h001, 4, 4);
    add(8'h34, 7, 1, 1, 0, 12'h081, 4, 4);
    add(8'hF0, 7, 1, 0, 0, 12'h081, 4, 4);
    add(8'h34, 0, 1, 1, 0, 12'h001, 4, 4);
    // Release a non-sounding key
    add(8'h35, 8, 1, 1, 0, 12'h101, 4, 4);
    add(8'hF0, 8, 1, 0, 0, 12'h101, 4, 4);
    add(8'h1C, 8, 1, 0, 0, 12'h100, 4, 4);
    add(8'hF0, 8, 1, 0, 0, 12'h100, 4, 4);
    add(8'h35, 8, 0, 0, 1, 12'h000, 4, 4);
    // Octave up with a typematic repeat, then saturation at 7
    add(8'h22, 8, 0, 0, 0, 12'h000, 5, 4);
    add(8'h22, 8, 0, 0, 0, 12'h000, 5, 4);
    add(8'hF0, 8, 0, 0, 0, 12'h000, 5, 4);
    add(8'h22, 8, 0, 0, 0, 12'h000, 5, 4);
    for (int i = 0; i < 3; i++) begin
      logic [2:0] o;
      o = (i == 0) ? 3'd6 : 3'd7;
      add(8'h22, 8, 0, 0, 0, 12'h000, o, 4);
      add(8'hF0, 8, 0, 0, 0, 12'h000, o, 4);
      add(8'h22, 8, 0, 0, 0, 12'h000, o, 4);
    end
    // Amp down five times, saturating at 0
    for (int i = 0; i < 5; i++) begin
      logic [2:0] a;
      a = (i < 4) ? 3'(3 - i) : 3'd0;
      add(8'h16, 8, 0, 0, 0, 12'h000, 7, a);
      add(8'hF0, 8, 0, 0, 0, 12'h000, 7, a);
      add(8'h16, 8, 0, 0, 0, 12'h000, 7, a);
    end
    add(8'h1E, 8, 0, 0, 0, 12'h000, 7, 1);
    add(8'hF0, 8, 0, 0, 0, 12'h000, 7, 1);
    add(8'h1E, 8, 0, 0, 0, 12'h000, 7, 1);
    add(8'h1A, 8, 0, 0, 0, 12'h000, 6, 1);
    add(8'hF0, 8, 0, 0, 0, 12'h000, 6, 1);
    add(8'h1A, 8, 0, 0, 0, 12'h000, 6, 1);
    // Extended codes and unknown codes leave everything alone
    add(8'h3B, 11, 1, 1, 0, 12'h800, 6, 1);
    add(8'hE0, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'hF0, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'h3B, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'hE0, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'h3B, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'h15, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'hF0, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'h15, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'hF0, 11, 1, 0, 0, 12'h800, 6, 1);
    add(8'h3B, 11, 0, 0, 1, 12'h000, 6, 1);

    // Reset state
    #12;
    check("reset_state", pack(0, 0, 0, 0, 12'h000, 4, 4));
    @(negedge clk);
    resetn = 1'b1;

    foreach (vq[i]) begin
      send(vq[i].b);
      check($sformatf("vec%0d_%02h", i, vq[i].b),
            pack(vq[i].note, vq[i].gate, vq[i].on, vq[i].off, vq[i].held, vq[i].oct,
                 vq[i].amp));
    end

    // Pulse width: one idle cycle after the last note_off
    @(posedge clk);
    #1;
    check("off_pulse_width", pack(11, 0, 0, 0, 12'h000, 6, 1));

    // Reset in the middle of a break code
    send(8'hF0);
    check("brk_prefix", pack(11, 0, 0, 0, 12'h000, 6, 1));
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset", pack(0, 0, 0, 0, 12'h000, 4, 4));
    @(negedge clk);
    resetn = 1'b1;
    send(8'h1C);
    check("make_after_reset", pack(0, 1, 1, 0, 12'h001, 4, 4));
    @(posedge clk);
    #1;
    check("on_pulse_width", pack(0, 1, 0, 0, 12'h001, 4, 4));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
